// File: rtl/nanov_spi_bus_sched.sv
`default_nettype none
// ============================================================================
// Module      : nanov_spi_bus_sched
// Description : Bit-serial SPI bus sequencer shared by the instruction stream
//               and load/store accesses; data pre-empts at word boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module nanov_spi_bus_sched #(
  parameter logic [7:0] RD_CMD = 8'h03,
  parameter logic [7:0] WR_CMD = 8'h02
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_req,
  input  logic        instr_start,
  input  logic [23:0] instr_addr,
  input  logic        instr_hold,
  output logic        instr_bit_valid,
  output logic        instr_word_done,
  output logic [23:0] fetch_addr,
  input  logic        data_req,
  input  logic        data_write,
  input  logic [1:0]  data_size,
  input  logic [23:0] data_addr,
  input  logic        data_wbit,
  output logic        data_wbit_ack,
  output logic        data_rbit_valid,
  output logic        data_done,
  output logic        spi_select,
  output logic        spi_clk_enable,
  output logic        spi_out,
  input  logic        spi_data_in
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_XFER  = 3'd3,
    S_STALL = 3'd4,
    S_DESEL = 3'd5
  } state_t;

  state_t      r_state, w_nstate;
  logic [5:0]  r_cnt, w_ncnt;
  logic        r_gnt_data, w_ngnt_data;
  logic        r_gnt_instr, w_ngnt_instr;
  logic [23:0] r_addr, w_naddr;
  logic        r_write, w_nwrite;
  logic [1:0]  r_size, w_nsize;
  logic [23:0] r_fetch, w_nfetch;
  logic [23:0] w_fetch_src;
  logic [7:0]  w_cmd_n;
  logic        r_spi_select, r_spi_clk_enable, r_spi_out;
  logic        r_instr_bit_valid, r_instr_word_done;
  logic        r_data_wbit_ack, r_data_rbit_valid, r_data_done;
  logic        w_unused;

  // spi_data_in is routed straight to the consumers; only the valids qualify it
  assign w_unused = spi_data_in;

  function automatic logic [5:0] last_idx(input logic [1:0] size);
    case (size)
      2'd0:    last_idx = 6'd7;
      2'd1:    last_idx = 6'd15;
      default: last_idx = 6'd31;
    endcase
  endfunction

  assign w_fetch_src = instr_start ? instr_addr : r_fetch;

  always_comb begin
    w_nstate     = r_state;
    w_ncnt       = r_cnt + 6'd1;
    w_ngnt_data  = r_gnt_data;
    w_ngnt_instr = r_gnt_instr;
    w_naddr      = r_addr;
    w_nwrite     = r_write;
    w_nsize      = r_size;
    w_nfetch     = r_fetch;
    case (r_state)
      S_IDLE: begin
        w_ncnt = '0;
        if (data_req) begin
          w_nstate     = S_CMD;
          w_ngnt_data  = 1'b1;
          w_ngnt_instr = 1'b0;
          w_naddr      = data_addr;
          w_nwrite     = data_write;
          w_nsize      = data_size;
        end else if (instr_req) begin
          w_nstate     = S_CMD;
          w_ngnt_data  = 1'b0;
          w_ngnt_instr = 1'b1;
          w_naddr      = w_fetch_src;
          w_nwrite     = 1'b0;
          w_nsize      = 2'd2;
        end
      end
      S_CMD: begin
        if (r_cnt == 6'd7) begin
          w_nstate = S_ADDR;
          w_ncnt   = '0;
        end
      end
      S_ADDR: begin
        if (r_cnt == 6'd23) begin
          w_nstate = S_XFER;
          w_ncnt   = '0;
        end
      end
      S_XFER: begin
        if (r_gnt_instr) begin
          if (r_cnt == 6'd31) begin
            w_ncnt   = '0;
            w_nfetch = r_fetch + 24'd4;
            if (data_req || !instr_req) begin
              w_nstate = S_DESEL;
            end else if (instr_hold) begin
              w_nstate = S_STALL;
            end
          end
        end else if (r_cnt == last_idx(r_size)) begin
          w_nstate = S_DESEL;
          w_ncnt   = '0;
        end
      end
      S_STALL: begin
        w_ncnt = '0;
        if (data_req || !instr_req) begin
          w_nstate = S_DESEL;
        end else if (!instr_hold) begin
          w_nstate = S_XFER;
        end
      end
      S_DESEL: begin
        w_nstate     = S_IDLE;
        w_ncnt       = '0;
        w_ngnt_data  = 1'b0;
        w_ngnt_instr = 1'b0;
      end
      default: begin
        w_nstate = S_IDLE;
        w_ncnt   = '0;
      end
    endcase
    // A branch kills the in-flight fetch frame, but never a data access
    if (instr_start && r_gnt_instr && (r_state != S_IDLE) && (r_state != S_DESEL)) begin
      w_nstate = S_DESEL;
      w_ncnt   = '0;
    end
    if (instr_start) begin
      w_nfetch = instr_addr;
    end
  end

  assign w_cmd_n = (w_ngnt_data && w_nwrite) ? WR_CMD : RD_CMD;

  // Outputs are decoded from the next state so they align with the state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state           <= S_IDLE;
      r_cnt             <= '0;
      r_gnt_data        <= 1'b0;
      r_gnt_instr       <= 1'b0;
      r_addr            <= '0;
      r_write           <= 1'b0;
      r_size            <= 2'd0;
      r_fetch           <= '0;
      r_spi_select      <= 1'b1;
      r_spi_clk_enable  <= 1'b1;
      r_spi_out         <= 1'b0;
      r_instr_bit_valid <= 1'b0;
      r_instr_word_done <= 1'b0;
      r_data_wbit_ack   <= 1'b0;
      r_data_rbit_valid <= 1'b0;
      r_data_done       <= 1'b0;
    end else begin
      r_state           <= w_nstate;
      r_cnt             <= w_ncnt;
      r_gnt_data        <= w_ngnt_data;
      r_gnt_instr       <= w_ngnt_instr;
      r_addr            <= w_naddr;
      r_write           <= w_nwrite;
      r_size            <= w_nsize;
      r_fetch           <= w_nfetch;
      r_spi_select      <= (w_nstate == S_IDLE) || (w_nstate == S_DESEL);
      r_spi_clk_enable  <= (w_nstate != S_STALL);
      r_spi_out         <= (w_nstate == S_CMD)  ? w_cmd_n[~w_ncnt[2:0]] :
                           (w_nstate == S_ADDR) ? w_naddr[5'd23 - w_ncnt[4:0]] : 1'b0;
      r_instr_bit_valid <= (w_nstate == S_XFER) && w_ngnt_instr;
      r_instr_word_done <= (w_nstate == S_XFER) && w_ngnt_instr && (w_ncnt == 6'd31);
      r_data_wbit_ack   <= (w_nstate == S_XFER) && w_ngnt_data && w_nwrite;
      r_data_rbit_valid <= (w_nstate == S_XFER) && w_ngnt_data && !w_nwrite;
      r_data_done       <= (w_nstate == S_XFER) && w_ngnt_data && (w_ncnt == last_idx(w_nsize));
    end
  end

  assign spi_select      = r_spi_select;
  assign spi_clk_enable  = r_spi_clk_enable;
  // Store bits pass straight through so data_wbit lands on the wire in its ack cycle
  assign spi_out         = r_data_wbit_ack ? data_wbit : r_spi_out;
  assign instr_bit_valid = r_instr_bit_valid;
  assign instr_word_done = r_instr_word_done;
  assign fetch_addr      = r_fetch;
  assign data_wbit_ack   = r_data_wbit_ack;
  assign data_rbit_valid = r_data_rbit_valid;
  assign data_done       = r_data_done;

endmodule
`default_nettype wire

// File: tb/tb_nanov_spi_bus_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_nanov_spi_bus_sched
// Description : Scoreboard bench for the SPI bus scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nanov_spi_bus_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic        instr_req, instr_start, instr_hold;
  logic [23:0] instr_addr;
  logic        instr_bit_valid, instr_word_done;
  logic [23:0] fetch_addr;
  logic        data_req, data_write;
  logic [1:0]  data_size;
  logic [23:0] data_addr;
  logic        data_wbit, data_wbit_ack, data_rbit_valid, data_done;
  logic        spi_select, spi_clk_enable, spi_out, spi_data_in;

  typedef struct {
    int          n;
    logic [31:0] w;
    bit          wr;
  } drec_t;

  logic [31:0] q_hdr[$];
  logic [23:0] q_word[$];
  drec_t       q_data[$];

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] w_word = 32'h0;
  int          widx = 0;

  always #5 clk = ~clk;

  nanov_spi_bus_sched dut (
    .clk             (clk),
    .rstn            (rstn),
    .instr_req       (instr_req),
    .instr_start     (instr_start),
    .instr_addr      (instr_addr),
    .instr_hold      (instr_hold),
    .instr_bit_valid (instr_bit_valid),
    .instr_word_done (instr_word_done),
    .fetch_addr      (fetch_addr),
    .data_req        (data_req),
    .data_write      (data_write),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wbit       (data_wbit),
    .data_wbit_ack   (data_wbit_ack),
    .data_rbit_valid (data_rbit_valid),
    .data_done       (data_done),
    .spi_select      (spi_select),
    .spi_clk_enable  (spi_clk_enable),
    .spi_out         (spi_out),
    .spi_data_in     (spi_data_in)
  );

  // Store source: MSB first, one bit per acknowledged cycle
  assign data_wbit = w_word[5'd31 - widx[4:0]];

  initial begin
    forever begin
      @(posedge clk);
      if (spi_select !== 1'b0) widx = 0;
      else if (data_wbit_ack === 1'b1) widx = widx + 1;
    end
  end

  initial begin
    spi_data_in = 1'b0;
    forever begin
      @(negedge clk);
      spi_data_in = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %h with nothing expected", nm, act);
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       cond = instr_word_done;
      1:       cond = spi_select;
      2:       cond = !spi_select;
      3:       cond = instr_bit_valid;
      4:       cond = data_done;
      5:       cond = data_rbit_valid;
      default: cond = data_wbit_ack;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cond(sel) !== 1'b1 && n < 3000);
    chk({"wait_", nm}, {31'd0, cond(sel)}, 32'd1);
  endtask

  // Monitor: reassembles frames and pops the scoreboard on each DUT event
  initial begin
    logic [31:0] hsh, dsh;
    int          hcnt, dn;
    drec_t       r;
    logic [23:0] ew;
    hsh = '0; dsh = '0; hcnt = 0; dn = 0;
    forever begin
      @(negedge clk);
      if (spi_select !== 1'b0) begin
        hcnt = 0; dn = 0; dsh = '0;
      end else begin
        if (spi_clk_enable === 1'b1 && hcnt < 32) begin
          hsh = {hsh[30:0], spi_out};
          hcnt++;
          if (hcnt == 32) begin
            if (q_hdr.size() == 0) fail_evt("hdr", hsh);
            else chk("hdr", hsh, q_hdr.pop_front());
          end
        end
        if (data_wbit_ack === 1'b1) begin
          dsh = {dsh[30:0], spi_out};
          dn++;
        end
        if (data_rbit_valid === 1'b1) dn++;
        if (data_done === 1'b1) begin
          if (q_data.size() == 0) fail_evt("data_done", 32'(dn));
          else begin
            r = q_data.pop_front();
            chk("data_bits", 32'(dn), 32'(r.n));
            if (r.wr) chk("store_data", dsh, r.w);
          end
          dn = 0; dsh = '0;
        end
        if (instr_word_done === 1'b1) begin
          if (q_word.size() == 0) fail_evt("word_done", {8'h0, fetch_addr});
          else begin
            ew = q_word.pop_front();
            chk("word_addr", {8'h0, fetch_addr}, {8'h0, ew});
          end
        end
      end
    end
  end

  initial begin
    int n;
    rstn = 1'b0; instr_req = 1'b0; instr_start = 1'b0; instr_hold = 1'b0; instr_addr = '0;
    data_req = 1'b0; data_write = 1'b0; data_size = 2'd0; data_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_select", {31'd0, spi_select}, 32'd1);
    chk("rst_clk_en", {31'd0, spi_clk_enable}, 32'd1);
    chk("rst_spi_out", {31'd0, spi_out}, 32'd0);
    chk("rst_fetch", {8'h0, fetch_addr}, 32'd0);
    chk("rst_valids", {27'd0, instr_bit_valid, instr_word_done, data_wbit_ack, data_rbit_valid, data_done}, 32'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Instruction stream from 0x100
    q_hdr.push_back(32'h03000100);
    q_word.push_back(24'h000100);
    q_word.push_back(24'h000104);
    instr_addr = 24'h000100; instr_start = 1'b1; instr_req = 1'b1;
    @(negedge clk);
    instr_start = 1'b0;
    wait_for(0, "word1", n);
    @(negedge clk);
    chk("fetch_after_word", {8'h0, fetch_addr}, 32'h000104);
    wait_for(0, "word2", n);
    instr_req = 1'b0;
    @(negedge clk);
    chk("stream_desel", {31'd0, spi_select}, 32'd1);
    repeat (3) @(negedge clk);

    // Word store with latency check
    q_hdr.push_back(32'h02001234);
    q_data.push_back('{n: 32, w: 32'hDEADBEEF, wr: 1'b1});
    w_word = 32'hDEADBEEF;
    data_req = 1'b1; data_write = 1'b1; data_size = 2'd2; data_addr = 24'h001234;
    @(negedge clk);
    data_req = 1'b0;
    wait_for(6, "first_ack", n);
    chk("store_latency", 32'(n + 1), 32'd33);
    wait_for(4, "store_done", n);
    @(negedge clk);
    chk("store_desel_sel", {31'd0, spi_select}, 32'd1);
    chk("store_desel_out", {31'd0, spi_out}, 32'd0);
    repeat (3) @(negedge clk);

    // Load pre-empts stream mid-word, then hold/stall on the resumed stream
    q_hdr.push_back(32'h03000200);
    q_hdr.push_back(32'h0300ABCD);
    q_hdr.push_back(32'h03000204);
    q_word.push_back(24'h000200);
    q_word.push_back(24'h000204);
    q_word.push_back(24'h000208);
    q_data.push_back('{n: 8, w: 32'h0, wr: 1'b0});
    instr_addr = 24'h000200; instr_start = 1'b1; instr_req = 1'b1;
    @(negedge clk);
    instr_start = 1'b0;
    wait_for(3, "pre_bits", n);
    repeat (10) @(negedge clk);
    data_req = 1'b1; data_write = 1'b0; data_size = 2'd0; data_addr = 24'h00ABCD;
    wait_for(1, "pre_desel", n);
    chk("pre_fetch", {8'h0, fetch_addr}, 32'h000204);
    wait_for(2, "load_sel", n);
    data_req = 1'b0;
    wait_for(1, "load_desel", n);
    wait_for(2, "resume_sel", n);
    wait_for(3, "resume_bits", n);
    instr_hold = 1'b1;
    wait_for(0, "hold_word", n);
    @(negedge clk);
    chk("stall_clk_en", {31'd0, spi_clk_enable}, 32'd0);
    chk("stall_select", {31'd0, spi_select}, 32'd0);
    chk("stall_valid", {31'd0, instr_bit_valid}, 32'd0);
    repeat (2) @(negedge clk);
    instr_hold = 1'b0;
    @(negedge clk);
    chk("release_valid", {31'd0, instr_bit_valid}, 32'd1);
    chk("release_clk_en", {31'd0, spi_clk_enable}, 32'd1);
    wait_for(0, "post_hold_word", n);
    instr_req = 1'b0;
    repeat (4) @(negedge clk);

    // Branch during ADDR aborts and restarts at 0x400
    q_hdr.push_back(32'h03000400);
    q_word.push_back(24'h000400);
    instr_addr = 24'h000300; instr_start = 1'b1; instr_req = 1'b1;
    @(negedge clk);
    instr_start = 1'b0;
    wait_for(2, "abort_sel", n);
    repeat (11) @(negedge clk);
    instr_addr = 24'h000400; instr_start = 1'b1;
    @(negedge clk);
    instr_start = 1'b0;
    chk("abort_desel", {31'd0, spi_select}, 32'd1);
    chk("abort_fetch", {8'h0, fetch_addr}, 32'h000400);
    wait_for(0, "restart_word", n);
    instr_req = 1'b0;
    repeat (4) @(negedge clk);

    // Branch and load together in IDLE, then reset mid-transfer
    q_hdr.push_back(32'h03000777);
    instr_addr = 24'h000500; instr_start = 1'b1; instr_req = 1'b1;
    data_req = 1'b1; data_write = 1'b0; data_size = 2'd1; data_addr = 24'h000777;
    @(negedge clk);
    instr_start = 1'b0; data_req = 1'b0;
    wait_for(5, "race_load", n);
    chk("race_fetch", {8'h0, fetch_addr}, 32'h000500);
    repeat (5) @(negedge clk);
    rstn = 1'b0; instr_req = 1'b0;
    @(negedge clk);
    chk("midrst_select", {31'd0, spi_select}, 32'd1);
    chk("midrst_rvalid", {31'd0, data_rbit_valid}, 32'd0);
    chk("midrst_fetch", {8'h0, fetch_addr}, 32'd0);
    chk("midrst_spi_out", {31'd0, spi_out}, 32'd0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", {31'd0, spi_select}, 32'd1);

    chk("hdr_left", 32'(q_hdr.size()), 32'd0);
    chk("word_left", 32'(q_word.size()), 32'd0);
    chk("data_left", 32'(q_data.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
